mem_port_arbiter: RTL

//  Shares the single data read/write port of the unified byte-addressed memory between N_REQ requesters,
//  e.g. core load/store unit (req 0) and debug/boot loader (req 1). Round-robin grant, valid/ready request

---
 rtl/mem_port_arbiter_pkg.sv | 48 ++++
 rtl/mem_port_arbiter_rr_arbiter.sv | 57 +++++
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared types and helpers for the data-port arbiter.
//   - mem_size_e     : access size encoding (byte, half, word, illegal)
//   - size_to_bytes  : byte count for a size (0 for illegal)
//   - extend_load    : keep the low bytes of a fetched word, then sign- or
//                      zero-extend them to 64 bits (callers truncate to their
//                      own data width)
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      MEM_B       = 2'd0,
      MEM_H       = 2'd1,
      MEM_W       = 2'd2,
      MEM_ILLEGAL = 2'd3
   } mem_size_e;

   // Widest data path the helpers handle.
   localparam int unsigned MaxDataWidth = 64;

   function automatic logic [3:0] size_to_bytes(input mem_size_e size);
      logic [3:0] n;
      case (size)
         MEM_B:   n = 4'd1;
         MEM_H:   n = 4'd2;
         MEM_W:   n = 4'd4;
         default: n = 4'd0;
      endcase
      return n;
   endfunction

   function automatic logic [MaxDataWidth-1:0] extend_load(
      input logic [MaxDataWidth-1:0] data,
      input mem_size_e               size,
      input logic                    sgn
   );
      logic [MaxDataWidth-1:0] res;
      case (size)
         MEM_B:   res = sgn ? {{56{data[7]}},  data[7:0]}  : {56'd0, data[7:0]};
         MEM_H:   res = sgn ? {{48{data[15]}}, data[15:0]} : {48'd0, data[15:0]};
         MEM_W:   res = sgn ? {{32{data[31]}}, data[31:0]} : {32'd0, data[31:0]};
         default: res = '0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter with an internal rotating pointer. The search starts
//   at the pointer and walks upward modulo N; the first active request wins.
//   When a grant is taken (i_advance), the pointer moves to one past the
//   winner, so a continuously asserted request is served within N cycles.
// Ports
//   i_clk        clock
//   i_rst        synchronous reset, active-high (pointer -> 0)
//   i_req        N request lines
//   i_advance    consume the current grant (pointer updates only on a grant)
//   o_grant      one-hot grant, or zero when nothing requests
//   o_grant_idx  binary index of the granted line (0 when no grant)
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int unsigned N = 2
) (
   input  logic                                i_clk,
   input  logic                                i_rst,
   input  logic [N-1:0]                        i_req,
   input  logic                                i_advance,
   output logic [N-1:0]                        o_grant,
   output logic [((N > 1) ? $clog2(N) : 1)-1:0] o_grant_idx
);

   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_ptr_next;
   logic [PW-1:0] w_idx;
   logic          w_found;

   always_comb begin
      o_grant     = '0;
      o_grant_idx = '0;
      w_found     = 1'b0;
      w_idx       = '0;
      for (int unsigned off = 0; off < N; off++) begin
         w_idx = PW'((32'(r_ptr) + off) % N);
         if (!w_found && i_req[w_idx]) begin
            o_grant[w_idx] = 1'b1;
            o_grant_idx    = w_idx;
            w_found        = 1'b1;
         end
      end
      w_ptr_next = (o_grant_idx == PW'(N - 1)) ? '0 : o_grant_idx + 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ptr <= '0;
      end else if (i_advance && w_found) begin
         r_ptr <= w_ptr_next;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the single data read/write port of a unified byte-addressed memory
//   between N_REQ requesters. Round-robin grant with a valid/ready handshake,
//   combinational memory drive in the grant cycle, registered response one
//   cycle later. Derives the byte count from the access size, sign/zero
//   extends loads and reports illegal-size or out-of-range accesses as errors
//   (erroring stores never write).
// Ports
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_req_valid/o_req_ready  per-requester handshake (ready one-hot or zero)
//   i_req_write/_signed      store select, load sign-extension select
//   i_req_size/_addr/_wdata  access size (mem_size_e), byte address, store data
//   o_rsp_valid/_err/_rdata  one-cycle response pulse, error flag, load data
//   o_mem_fetch_addr         memory read address
//   i_mem_fetched_data       memory read data (combinational from fetch addr)
//   o_mem_write_addr         memory write address
//   o_mem_bytes_to_write     bytes to store this cycle, 0 = no write
//   o_mem_write_data         memory write data
// -----------------------------------------------------------------------------
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH    = 32,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter logic [63:0] MEM_BYTE_SIZE = 64'h1000,
   parameter int unsigned N_REQ         = 2
) (
   input  logic                                  i_clk,
   input  logic                                  i_rst,
   input  logic [N_REQ-1:0]                      i_req_valid,
   output logic [N_REQ-1:0]                      o_req_ready,
   input  logic [N_REQ-1:0]                      i_req_write,
   input  logic [N_REQ-1:0]                      i_req_signed,
   input  logic [N_REQ-1:0][1:0]                 i_req_size,
   input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]      i_req_addr,
   input  logic [N_REQ-1:0][DATA_WIDTH-1:0]      i_req_wdata,
   output logic [N_REQ-1:0]                      o_rsp_valid,
   output logic [N_REQ-1:0]                      o_rsp_err,
   output logic [N_REQ-1:0][DATA_WIDTH-1:0]      o_rsp_rdata,
   output logic [ADDR_WIDTH-1:0]                 o_mem_fetch_addr,
   input  logic [DATA_WIDTH-1:0]                 i_mem_fetched_data,
   output logic [ADDR_WIDTH-1:0]                 o_mem_write_addr,
   output logic [$clog2(DATA_WIDTH/8):0]         o_mem_bytes_to_write,
   output logic [DATA_WIDTH-1:0]                 o_mem_write_data
);

   localparam int unsigned GW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned BTW_W = $clog2(DATA_WIDTH / 8) + 1;
   localparam int unsigned AW1   = ADDR_WIDTH + 1;

   // Arbitration
   logic [N_REQ-1:0] w_req;
   logic [N_REQ-1:0] w_grant;
   logic [GW-1:0]    w_gidx;
   logic             w_any;

   // Reset masks requests so no transfer can coincide with reset.
   assign w_req = i_rst ? '0 : i_req_valid;

   rr_arbiter #(
      .N (N_REQ)
   ) u_rr_arbiter (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_req       (w_req),
      .i_advance   (1'b1),
      .o_grant     (w_grant),
      .o_grant_idx (w_gidx)
   );

   assign w_any       = |w_grant;
   assign o_req_ready = w_grant;

   // Granted request decode and checks
   mem_size_e             w_size;
   logic [3:0]            w_nbytes;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [AW1-1:0]        w_end;
   logic                  w_write;
   logic                  w_err;
   logic [DATA_WIDTH-1:0] w_load;

   assign w_size   = mem_size_e'(i_req_size[w_gidx]);
   assign w_nbytes = size_to_bytes(w_size);
   assign w_addr   = i_req_addr[w_gidx];
   assign w_write  = i_req_write[w_gidx];

   // One extra bit so an access running past the top of the address space
   // cannot wrap around and look in range.
   assign w_end = {1'b0, w_addr} + AW1'(w_nbytes);
   assign w_err = (w_size == MEM_ILLEGAL) || (64'(w_end) > MEM_BYTE_SIZE);

   assign w_load = DATA_WIDTH'(extend_load(64'(i_mem_fetched_data), w_size,
                                           i_req_signed[w_gidx]));

   // Memory drive, valid only in the grant cycle
   always_comb begin
      o_mem_fetch_addr     = '0;
      o_mem_write_addr     = '0;
      o_mem_write_data     = '0;
      o_mem_bytes_to_write = '0;
      if (w_any) begin
         o_mem_fetch_addr = w_addr;
         o_mem_write_addr = w_addr;
         o_mem_write_data = i_req_wdata[w_gidx];
         if (w_write && !w_err) begin
            o_mem_bytes_to_write = BTW_W'(w_nbytes);
         end
      end
   end

   // Response next-state
   logic [N_REQ-1:0]                 w_rsp_err_d;
   logic [N_REQ-1:0][DATA_WIDTH-1:0] w_rsp_rdata_d;

   always_comb begin
      w_rsp_err_d   = w_err ? w_grant : '0;
      w_rsp_rdata_d = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_grant[i] && !w_err && !w_write) begin
            w_rsp_rdata_d[i] = w_load;
         end
      end
   end

   // Response registers
   logic [N_REQ-1:0]                 r_rsp_valid;
   logic [N_REQ-1:0]                 r_rsp_err;
   logic [N_REQ-1:0][DATA_WIDTH-1:0] r_rsp_rdata;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rsp_valid <= '0;
         r_rsp_err   <= '0;
         r_rsp_rdata <= '0;
      end else begin
         r_rsp_valid <= w_grant;
         r_rsp_err   <= w_rsp_err_d;
         r_rsp_rdata <= w_rsp_rdata_d;
      end
   end

   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_err   = r_rsp_err;
   assign o_rsp_rdata = r_rsp_rdata;

endmodule
